// File: rtl/chan_regs.sv
// Register-mapped bridge between the CPU register bus and NCHAN byte-stream channels.
// Optional RX-level interrupt logic is built when CHAN_REGS_IRQ_EN is defined.
module chan_regs #(
  parameter int unsigned NCHAN = 2,
  parameter int unsigned DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reg_req,
  input  logic                 reg_wr,
  input  logic [7:0]           reg_addr,
  input  logic [31:0]          reg_wdata,
  output logic                 reg_ack,
  output logic [31:0]          reg_rdata,
  output logic [NCHAN-1:0]     tx_valid,
  output logic [8*NCHAN-1:0]   tx_data,
  input  logic [NCHAN-1:0]     tx_ready,
  input  logic [NCHAN-1:0]     rx_valid,
  input  logic [8*NCHAN-1:0]   rx_data,
  output logic [NCHAN-1:0]     rx_ready,
  output logic [15:0]          mouse_x,
  output logic [15:0]          mouse_y,
  output logic                 irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  ptr_t       tx_wptr_q [NCHAN];
  ptr_t       tx_rptr_q [NCHAN];
  ptr_t       rx_wptr_q [NCHAN];
  ptr_t       rx_rptr_q [NCHAN];
  logic [7:0] tx_mem    [NCHAN][DEPTH];
  logic [7:0] rx_mem    [NCHAN][DEPTH];
  ptr_t       tx_cnt    [NCHAN];
  ptr_t       rx_cnt    [NCHAN];

  logic [NCHAN-1:0] tx_ovf_q;
  logic [15:0]      mouse_x_q, mouse_y_q;
  logic             ack_q;
  logic [31:0]      rdata_q, rdata_d;

  logic [NCHAN-1:0] tx_full, rx_full, rx_ne;
  logic [NCHAN-1:0] tx_push, tx_pop, rx_push, rx_pop;
  logic [NCHAN-1:0] ovf_set, ovf_clr;
  logic [3:0]       reg_chan, reg_off;

`ifdef CHAN_REGS_IRQ_EN
  logic [NCHAN-1:0] en_q, en_wr;
  logic             irq_q;
`endif

  assign reg_chan = reg_addr[7:4];
  assign reg_off  = reg_addr[3:0];

  always_comb begin
    rdata_d  = '0;
    tx_full  = '0;
    rx_full  = '0;
    rx_ne    = '0;
    tx_valid = '0;
    tx_data  = '0;
    rx_ready = '0;
    tx_push  = '0;
    tx_pop   = '0;
    rx_push  = '0;
    rx_pop   = '0;
    ovf_set  = '0;
    ovf_clr  = '0;
`ifdef CHAN_REGS_IRQ_EN
    en_wr    = '0;
`endif
    for (int c = 0; c < NCHAN; c++) begin
      tx_cnt[c]       = tx_wptr_q[c] - tx_rptr_q[c];
      rx_cnt[c]       = rx_wptr_q[c] - rx_rptr_q[c];
      tx_full[c]      = (tx_cnt[c] == ptr_t'(DEPTH));
      rx_full[c]      = (rx_cnt[c] == ptr_t'(DEPTH));
      rx_ne[c]        = (rx_cnt[c] != '0);
      tx_valid[c]     = (tx_cnt[c] != '0);
      tx_data[8*c+:8] = tx_mem[c][tx_rptr_q[c][AW-1:0]];
      rx_ready[c]     = ~rx_full[c];
      tx_pop[c]       = tx_valid[c] & tx_ready[c];
      rx_push[c]      = rx_valid[c] & ~rx_full[c];

      if (reg_req && reg_chan == 4'(c)) begin
        if (reg_wr) begin
          if (reg_off == 4'h0) begin
            // A same-cycle TX pop frees a slot, so a full FIFO still accepts the byte.
            if (!tx_full[c] || tx_pop[c]) tx_push[c] = 1'b1;
            else                          ovf_set[c] = 1'b1;
          end
`ifdef CHAN_REGS_IRQ_EN
          if (reg_off == 4'h8) en_wr[c] = 1'b1;
`endif
        end else begin
          case (reg_off)
            4'h0: begin
              rdata_d   = {~rx_ne[c], 23'b0,
                           rx_ne[c] ? rx_mem[c][rx_rptr_q[c][AW-1:0]] : 8'h00};
              rx_pop[c] = rx_ne[c];
            end
            4'h4: begin
              rdata_d    = {8'b0, 8'(rx_cnt[c]), 8'(tx_cnt[c]),
                            5'b0, tx_ovf_q[c], rx_ne[c], tx_full[c]};
              ovf_clr[c] = 1'b1;
            end
`ifdef CHAN_REGS_IRQ_EN
            4'h8: rdata_d = {31'b0, en_q[c]};
`endif
            default: ;
          endcase
        end
      end
    end

    if (reg_req && !reg_wr) begin
      if (reg_addr == 8'hF0) rdata_d = {mouse_y_q, mouse_x_q};
`ifdef CHAN_REGS_IRQ_EN
      if (reg_addr == 8'hF4) rdata_d = 32'(rx_ne & en_q);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCHAN; c++) begin
        tx_wptr_q[c] <= '0;
        tx_rptr_q[c] <= '0;
        rx_wptr_q[c] <= '0;
        rx_rptr_q[c] <= '0;
      end
      tx_ovf_q  <= '0;
      mouse_x_q <= '0;
      mouse_y_q <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        if (tx_push[c]) tx_wptr_q[c] <= tx_wptr_q[c] + 1'b1;
        if (tx_pop[c])  tx_rptr_q[c] <= tx_rptr_q[c] + 1'b1;
        if (rx_push[c]) rx_wptr_q[c] <= rx_wptr_q[c] + 1'b1;
        if (rx_pop[c])  rx_rptr_q[c] <= rx_rptr_q[c] + 1'b1;
      end
      // A new overflow takes priority over the read-to-clear.
      tx_ovf_q <= (tx_ovf_q & ~ovf_clr) | ovf_set;
      ack_q    <= reg_req;
      if (reg_req && !reg_wr) rdata_q <= rdata_d;
      if (reg_req && reg_wr && reg_addr == 8'hF0) begin
        mouse_x_q <= reg_wdata[15:0];
        mouse_y_q <= reg_wdata[31:16];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCHAN; c++) begin
      if (tx_push[c]) tx_mem[c][tx_wptr_q[c][AW-1:0]] <= reg_wdata[7:0];
      if (rx_push[c]) rx_mem[c][rx_wptr_q[c][AW-1:0]] <= rx_data[8*c+:8];
    end
  end

`ifdef CHAN_REGS_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        if (en_wr[c]) en_q[c] <= reg_wdata[0];
      end
      irq_q <= |(rx_ne & en_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign reg_ack   = ack_q;
  assign reg_rdata = rdata_q;
  assign mouse_x   = mouse_x_q;
  assign mouse_y   = mouse_y_q;

endmodule
